hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It drives the 2-bit selects of the EX-stage operand forwarding muxes and detects load-use hazards. It sequences a multi-cycle divide stall through a small FSM and generates the IF/ID hold and ID/EX flush signals. It sits beside the decode/execute stages and is the only block that produces `fwd_a`/`fwd_b` and the stall/flush strobes.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/div_stall_fsm.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// forwarding-mux select codes and the divide-stall FSM state encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// Divide stall sequencer: holds the front of the pipeline for exactly
// DIV_LAT cycles per divide (one IDLE cycle plus DIV_LAT-1 BUSY cycles),
// then spends one DONE cycle while the finished divide leaves EX.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic stall,
  output logic busy
);

  localparam logic [7:0] CNT_LOAD = 8'(DIV_LAT - 2);

  div_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  // State and countdown registers; reset drops the FSM to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and stall decode; the start cycle already stalls from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 8'd0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding selects, load-use
// detection, branch flush and multi-cycle divide stall.
// Build option: define HAZARD_DIV_STALL_EN to include the divide stall FSM;
// without it stall_ex/div_busy are tied low and ex_div_start is ignored.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_div_start,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             div_busy
);

  logic div_stall;
  logic div_active;
  logic load_use;
  logic branch_flush;

  // The newer EX/MEM value wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

`ifdef HAZARD_DIV_STALL_EN
  div_stall_fsm #(
    .DIV_LAT(DIV_LAT)
  ) u_div_stall (
    .clk  (clk),
    .rst  (rst),
    .start(ex_div_start && !ex_branch_taken),
    .stall(div_stall),
    .busy (div_active)
  );
`else
  localparam int unused_div_lat = DIV_LAT;
  logic unused_div_inputs;
  assign unused_div_inputs = ^{clk, rst, ex_div_start};
  assign div_stall  = 1'b0;
  assign div_active = 1'b0;
`endif

  // Operand forwarding selects for both EX source registers.
  always_comb begin
    fwd_a = fwd_sel(ex_rs1);
    fwd_b = fwd_sel(ex_rs2);
  end

  // A branch seen while a divide is in flight cannot legally happen, so it
  // is simply ignored there rather than allowed to disturb the divide.
  assign load_use     = ex_memread && (ex_rd != '0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign branch_flush = ex_branch_taken && !div_active;

  // Stall/flush strobes by priority: divide, then branch, then load-use.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (div_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (branch_flush) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  assign div_busy = div_active;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Divide-stall scenarios
// follow the HAZARD_DIV_STALL_EN build option of the design.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_memread, ex_div_start, ex_branch_taken;
  logic       mem_regwrite, wb_regwrite;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, div_busy;

  int checks = 0;
  int errors = 0;

  // Observed outputs packed as {fwd_a, fwd_b, stall_if, stall_id, stall_ex,
  // flush_id, flush_ex, div_busy}.
  logic [9:0] outs;
  assign outs = {fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_id, flush_ex, div_busy};

  hazard_ctrl #(
    .DIV_LAT(8),
    .REG_W  (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_memread     (ex_memread),
    .ex_div_start   (ex_div_start),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd         (mem_rd),
    .mem_regwrite   (mem_regwrite),
    .wb_rd          (wb_rd),
    .wb_regwrite    (wb_regwrite),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .div_busy       (div_busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_rd = 0; wb_rd = 0;
    ex_memread = 0; ex_div_start = 0; ex_branch_taken = 0;
    mem_regwrite = 0; wb_regwrite = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_idle: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_forwarding();
    // fwd_a: both stages match -> EX/MEM
    @(negedge clk);
    clear_inputs();
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
    #1;
    checks++;
    if (outs !== {2'b01, 2'b00, 6'b0}) begin
      errors++;
      $display("[TB] FAIL fwd_a_both_match: got %b expected %b", outs, {2'b01, 2'b00, 6'b0});
    end
    mem_regwrite = 0;
    #1;
    checks++;
    if (outs !== {2'b10, 2'b00, 6'b0}) begin
      errors++;
      $display("[TB] FAIL fwd_a_wb_only: got %b expected %b", outs, {2'b10, 2'b00, 6'b0});
    end
    ex_rs1 = 0; mem_rd = 0; mem_regwrite = 1; wb_rd = 0;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL fwd_a_x0: got %b expected %b", outs, 10'b0);
    end
    // fwd_b paths
    @(negedge clk);
    clear_inputs();
    ex_rs2 = 9; ex_rs1 = 3; mem_rd = 9; mem_regwrite = 0; wb_rd = 9; wb_regwrite = 1;
    #1;
    checks++;
    if (outs !== {2'b00, 2'b10, 6'b0}) begin
      errors++;
      $display("[TB] FAIL fwd_b_wb_mem_disabled: got %b expected %b", outs, {2'b00, 2'b10, 6'b0});
    end
    mem_regwrite = 1; wb_rd = 3;
    #1;
    checks++;
    if (outs !== {2'b10, 2'b01, 6'b0}) begin
      errors++;
      $display("[TB] FAIL fwd_split_ab: got %b expected %b", outs, {2'b10, 2'b01, 6'b0});
    end
    wb_regwrite = 0; mem_rd = 4;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL fwd_no_match: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_rs1 = 2;
    #1;
    checks++;
    if (outs !== 10'b0000_110010) begin
      errors++;
      $display("[TB] FAIL load_use_rs2: got %b expected %b", outs, 10'b0000_110010);
    end
    @(negedge clk);
    ex_memread = 0;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL load_use_one_cycle: got %b expected %b", outs, 10'b0);
    end
    @(negedge clk);
    ex_memread = 1; ex_rd = 2; id_rs2 = 8;
    #1;
    checks++;
    if (outs !== 10'b0000_110010) begin
      errors++;
      $display("[TB] FAIL load_use_rs1: got %b expected %b", outs, 10'b0000_110010);
    end
    @(negedge clk);
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL load_use_x0: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; ex_branch_taken = 1;
    #1;
    checks++;
    if (outs !== 10'b0000_000110) begin
      errors++;
      $display("[TB] FAIL branch_over_load_use: got %b expected %b", outs, 10'b0000_000110);
    end
    // A divide start coinciding with a taken branch must not launch.
    ex_div_start = 1;
    #1;
    checks++;
    if (outs !== 10'b0000_000110) begin
      errors++;
      $display("[TB] FAIL branch_blocks_div: got %b expected %b", outs, 10'b0000_000110);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL branch_no_div_after: got %b expected %b", outs, 10'b0);
    end
  endtask

`ifdef HAZARD_DIV_STALL_EN
  // One-cycle start pulse; checks cycles 1..10 (stall 1..8, busy 2..9).
  task automatic run_div_pulse(input string tag);
    logic [9:0] exp;
    logic s, b;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      clear_inputs();
      ex_div_start = (c == 1);
      #1;
      s = (c <= 8);
      b = (c >= 2) && (c <= 9);
      exp = {4'b0, s, s, s, 1'b0, 1'b0, b};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL %s_cycle%0d: got %b expected %b", tag, c, outs, exp);
      end
    end
  endtask

  task automatic test_divide();
    run_div_pulse("div_single");
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    logic s, b;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      clear_inputs();
      ex_div_start = (c <= 18);
      #1;
      s = (c <= 8) || ((c >= 10) && (c <= 17));
      b = ((c >= 2) && (c <= 9)) || ((c >= 11) && (c <= 18));
      exp = {4'b0, s, s, s, 1'b0, 1'b0, b};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL div_b2b_cycle%0d: got %b expected %b", c, outs, exp);
      end
    end
  endtask

  task automatic test_div_priority();
    // Load-use and a stray branch during BUSY are overridden by the divide.
    @(negedge clk);
    clear_inputs();
    ex_div_start = 1;
    #1;
    @(negedge clk);
    clear_inputs();
    ex_memread = 1; ex_rd = 4; id_rs1 = 4; ex_branch_taken = 1;
    #1;
    checks++;
    if (outs !== 10'b0000_111001) begin
      errors++;
      $display("[TB] FAIL div_over_branch_load: got %b expected %b", outs, 10'b0000_111001);
    end
    clear_inputs();
    for (int c = 3; c <= 10; c++) @(negedge clk);
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL div_priority_settle: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_reset_mid_div();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      clear_inputs();
      ex_div_start = (c == 1);
    end
    #1;
    checks++;
    if (outs !== 10'b0000_111001) begin
      errors++;
      $display("[TB] FAIL div_busy_before_rst: got %b expected %b", outs, 10'b0000_111001);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_div: got %b expected %b", outs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++;
      $display("[TB] FAIL rst_release_idle: got %b expected %b", outs, 10'b0);
    end
    run_div_pulse("div_after_rst");
  endtask
`else
  // Single-cycle divider build: divide starts never stall.
  task automatic test_divide();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      clear_inputs();
      ex_div_start = (c == 1);
      #1;
      checks++;
      if (outs !== 10'b0) begin
        errors++;
        $display("[TB] FAIL div_disabled_cycle%0d: got %b expected %b", c, outs, 10'b0);
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] starting hazard_ctrl bench");
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_divide();
`ifdef HAZARD_DIV_STALL_EN
    test_back_to_back();
    test_div_priority();
    test_reset_mid_div();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
